// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment code and pattern constants
package seg7_pkg;

   // Digit codes with special meaning beyond the hex range
   localparam logic [4:0] CODE_MINUS = 5'd16;
   localparam logic [4:0] CODE_BAD   = 5'd30;
   localparam logic [4:0] CODE_BLANK = 5'd31;

   // Segment patterns {a,b,c,d,e,f,g}, 1 = lit, shared with the encoder side
   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_A     = 7'b1110111;
   localparam logic [6:0] SEG_B     = 7'b0011111;
   localparam logic [6:0] SEG_C     = 7'b0001101;
   localparam logic [6:0] SEG_D     = 7'b0111101;
   localparam logic [6:0] SEG_E     = 7'b1001111;
   localparam logic [6:0] SEG_F     = 7'b1000111;
   localparam logic [6:0] SEG_MINUS = 7'b0000001;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_capture_if.sv
// rtl/seg7_capture_if.sv - multiplexed display bus and capture result signals
interface seg7_capture_if #(
   parameter int DIGITS = 8
);
   logic [7:0]          seg_in;
   logic [DIGITS-1:0]   dig_en;
   logic [5*DIGITS-1:0] codes;
   logic [DIGITS-1:0]   valid;
   logic                upd;
   logic [3:0]          upd_idx;
   logic                err;

   // Display side / bench drives the bus and observes the results
   modport master (
      output seg_in, dig_en,
      input  codes, valid, upd, upd_idx, err
   );

   // Capture block watches the bus and reports decoded digits
   modport slave (
      input  seg_in, dig_en,
      output codes, valid, upd, upd_idx, err
   );
endinterface

// File: rtl/seg7_pattern_dec.sv
// rtl/seg7_pattern_dec.sv - segment pattern to digit code lookup
module seg7_pattern_dec
   import seg7_pkg::*;
(
   input  logic [6:0] pat,
   output logic [4:0] code,
   output logic       known
);

   // Reverse lookup; anything not in the table is flagged as unrecognised
   always_comb begin
      code  = CODE_BAD;
      known = 1'b1;
      case (pat)
         SEG_0:     code = 5'd0;
         SEG_1:     code = 5'd1;
         SEG_2:     code = 5'd2;
         SEG_3:     code = 5'd3;
         SEG_4:     code = 5'd4;
         SEG_5:     code = 5'd5;
         SEG_6:     code = 5'd6;
         SEG_7:     code = 5'd7;
         SEG_8:     code = 5'd8;
         SEG_9:     code = 5'd9;
         SEG_A:     code = 5'd10;
         SEG_B:     code = 5'd11;
         SEG_C:     code = 5'd12;
         SEG_D:     code = 5'd13;
         SEG_E:     code = 5'd14;
         SEG_F:     code = 5'd15;
         SEG_MINUS: code = CODE_MINUS;
         SEG_BLANK: code = CODE_BLANK;
         default: begin
            code  = CODE_BAD;
            known = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - stability-qualified 7-segment bus capture and register bank
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int DIGITS = 8,
   parameter int STABLE = 4
) (
   input  logic           CLK,
   input  logic           RST,
   seg7_capture_if.slave  bus
);

   localparam int CW = $clog2(STABLE) + 1;

   logic [7:0]          seg_q;
   logic [DIGITS-1:0]   en_q;
   logic [CW-1:0]       cnt;
   logic                same;
   logic                one_hot;
   logic                commit;
   logic [4:0]          dec_code;
   logic                dec_known;
   logic [3:0]          idx;
   logic [5*DIGITS-1:0] codes_q;
   logic [DIGITS-1:0]   valid_q;
   logic                upd_q;
   logic                err_q;
   logic [3:0]          idx_q;

   // Incoming pair compared with the held sample; enable must be exactly one-hot
   always_comb begin
      same    = (bus.seg_in == seg_q) && (bus.dig_en == en_q);
      one_hot = (bus.dig_en != '0) &&
                ((bus.dig_en & (bus.dig_en - DIGITS'(1))) == '0);
      // The counter passes STABLE-1 exactly once per run because it saturates above it
      commit  = (cnt == CW'(STABLE - 1));
   end

   // Sample registers and saturating stability counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         seg_q <= '0;
         en_q  <= '0;
         cnt   <= '0;
      end else begin
         seg_q <= bus.seg_in;
         en_q  <= bus.dig_en;
         if (same && one_hot) begin
            if (cnt != '1) cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end

   seg7_pattern_dec u_dec (
      .pat   (seg_q[7:1]),
      .code  (dec_code),
      .known (dec_known)
   );

   // Position number of the held one-hot enable
   always_comb begin
      idx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (en_q[i]) idx = 4'(i);
      end
   end

   // Per-digit code bank, written only by a commit
   always_ff @(posedge CLK) begin
      if (RST) begin
         codes_q <= {DIGITS{CODE_BLANK}};
         valid_q <= '0;
      end else if (commit) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (en_q[i]) begin
               codes_q[5*i +: 5] <= dec_code;
               valid_q[i]        <= 1'b1;
            end
         end
      end
   end

   // Registered commit pulse, error pulse and last written position
   always_ff @(posedge CLK) begin
      if (RST) begin
         upd_q <= 1'b0;
         err_q <= 1'b0;
         idx_q <= '0;
      end else begin
         upd_q <= commit;
         err_q <= commit && !dec_known;
         if (commit) idx_q <= idx;
      end
   end

   assign bus.codes   = codes_q;
   assign bus.valid   = valid_q;
   assign bus.upd     = upd_q;
   assign bus.err     = err_q;
   assign bus.upd_idx = idx_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - scoreboard bench for seg7_capture
module tb_seg7_capture;

   localparam int DIGITS = 8;
   localparam int STABLE = 4;

   typedef struct {
      logic [3:0] idx;
      logic [4:0] code;
      logic       err;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   upd_seen = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   seg7_capture_if #(.DIGITS(DIGITS)) bus ();

   seg7_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [4:0] code_at(input int i);
      return bus.codes[5*i +: 5];
   endfunction

   // Drive a pair at a falling edge and hold it for n rising edges
   task automatic hold(input logic [7:0] seg, input logic [7:0] en, input int n,
                       input bit expect_commit, input int idx, input logic [4:0] code,
                       input logic e);
      exp_t x;
      bus.seg_in = seg;
      bus.dig_en = en;
      if (expect_commit) begin
         x.idx  = 4'(idx);
         x.code = code;
         x.err  = e;
         x.cyc  = cyc + STABLE + 1;
         exp_q.push_back(x);
      end
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every upd pulse must match the oldest expected commit
   always @(negedge clk) begin
      if (bus.upd === 1'b1) begin
         upd_seen++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_upd: upd_idx %0d, no commit expected", bus.upd_idx);
         end else begin
            mon_e = exp_q.pop_front();
            check("upd_idx", 64'(bus.upd_idx), 64'(mon_e.idx));
            check("upd_code", 64'(code_at(int'(mon_e.idx))), 64'(mon_e.code));
            check("upd_err", 64'(bus.err), 64'(mon_e.err));
            check("upd_valid", 64'(bus.valid[mon_e.idx]), 64'(1));
            check("upd_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
      if (bus.err === 1'b1 && bus.upd !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL err_without_upd: err 1, upd %0b", bus.upd);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0]          rr_pat [8];
      logic [5*DIGITS-1:0] snap;
      int                  u0;

      rr_pat = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0};
      bus.seg_in = 8'h00;
      bus.dig_en = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("reset_codes", 64'(bus.codes), 64'({DIGITS{5'd31}}));
      check("reset_valid", 64'(bus.valid), 64'(0));
      check("reset_upd", 64'(bus.upd), 64'(0));
      check("reset_upd_idx", 64'(bus.upd_idx), 64'(0));
      check("reset_err", 64'(bus.err), 64'(0));

      u0 = upd_seen;
      repeat (100) @(negedge clk);
      check("idle_no_upd", 64'(upd_seen - u0), 64'(0));
      check("idle_codes", 64'(bus.codes), 64'({DIGITS{5'd31}}));

      u0 = upd_seen;
      hold(8'hB6, 8'h04, 10, 1, 2, 5'd5, 1'b0);
      hold(8'h00, 8'h00, 2, 0, 0, 5'd0, 1'b0);
      check("long_hold_single_upd", 64'(upd_seen - u0), 64'(1));
      check("long_hold_code2", 64'(code_at(2)), 64'(5));
      check("long_hold_valid", 64'(bus.valid), 64'(8'h04));

      snap = bus.codes;
      u0 = upd_seen;
      hold(8'hB6, 8'h04, 3, 0, 0, 5'd0, 1'b0);
      hold(8'h00, 8'h00, 4, 0, 0, 5'd0, 1'b0);
      check("short_hold_no_upd", 64'(upd_seen - u0), 64'(0));
      check("short_hold_codes", 64'(bus.codes), 64'(snap));

      hold(8'h02, 8'h01, 5, 1, 0, 5'd16, 1'b0);
      hold(8'h00, 8'h02, 5, 1, 1, 5'd31, 1'b0);
      hold(8'hFF, 8'h80, 5, 1, 7, 5'd8, 1'b0);
      hold(8'h00, 8'h00, 2, 0, 0, 5'd0, 1'b0);
      check("minus_code0", 64'(code_at(0)), 64'(16));
      check("blank_code1", 64'(code_at(1)), 64'(31));
      check("dp_ignored_code7", 64'(code_at(7)), 64'(8));
      check("valid_after_three", 64'(bus.valid), 64'(8'h87));

      hold(8'h92, 8'h08, 5, 1, 3, 5'd30, 1'b1);
      hold(8'h00, 8'h00, 2, 0, 0, 5'd0, 1'b0);
      check("bad_code3", 64'(code_at(3)), 64'(30));
      u0 = upd_seen;
      hold(8'hB6, 8'h06, 20, 0, 0, 5'd0, 1'b0);
      hold(8'h00, 8'h00, 2, 0, 0, 5'd0, 1'b0);
      check("multi_hot_no_upd", 64'(upd_seen - u0), 64'(0));

      for (int i = 0; i < 8; i++) begin
         hold(rr_pat[i], 8'(1 << i), 6, 1, i, 5'(i), 1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         check($sformatf("scan_code%0d", i), 64'(code_at(i)), 64'(i));
      end
      check("scan_valid", 64'(bus.valid), 64'(8'hFF));

      u0 = upd_seen;
      bus.seg_in = rr_pat[0];
      bus.dig_en = 8'h01;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      hold(8'h00, 8'h00, 4, 0, 0, 5'd0, 1'b0);
      check("rst_abort_no_upd", 64'(upd_seen - u0), 64'(0));
      check("rst_codes_blank", 64'(bus.codes), 64'({DIGITS{5'd31}}));
      check("rst_valid_clear", 64'(bus.valid), 64'(0));

      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side counterpart of the team's 7-segment display encoder. It monitors a time-multiplexed 7-segment bus (segment pattern plus one-hot digit enable) and qualifies each pattern as stable. It then decodes stable patterns back into the same 5-bit digit codes the encoder consumes and stores them in a per-digit register bank. It sits in display-loopback and self-test paths, letting the processor or testbench read back what the display hardware is actually showing.

## Interface
- `DIGITS`, default 8: number of multiplexed digit positions; 1–16.
- `STABLE`, default 4: consecutive samples a pattern must hold before commit; ≥2.
- `CLK`  in  1: sole clock; all logic on rising edge.
- `RST`  in  1: reset; synchronous, active-high.
- `seg_in`  in  8: segment pattern; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp; 1=lit.
- `dig_en`  in  DIGITS: digit enable; bit i selects position i; must be one-hot to qualify.
- `codes`  out  5*DIGITS: stored codes; position i at bits [5i+4:5i].
- `valid`  out  DIGITS: bit i set once position i has committed at least once.
- `upd`  out  1: one-cycle pulse on each commit.
- `upd_idx`  out  4: position written by the commit flagged by `upd`.
- `err`  out  1: one-cycle pulse, coincident with `upd`, when the committed pattern is unrecognised.

## Operation
- Decode ignores dp (bit0) and maps `seg_in[7:1]` as follows: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A(10)=1110111, b(11)=0011111, c(12)=0001101, d(13)=0111101, E(14)=1001111, F(15)=1000111, minus(16)=0000001.
- Pattern 0000000 decodes to `CODE_BLANK`=31 and is legal, with no `err`.
- Any other pattern decodes to `CODE_BAD`=30 and raises `err` on commit.
- Input pair {`seg_in`, `dig_en`} is registered once, then compared against the previous sample.
- Stability counter: on each edge, if the new sample equals the previous sample and `dig_en` is one-hot, it increments (saturating). Otherwise it clears to 0.
- Commit condition: counter reaches STABLE-1 for the first time since the last clear. Exactly one commit per held pair.
- On commit:
  - `codes[idx]` gets the decoded code and `valid[idx]` is set to 1.
  - `upd`=1 and `upd_idx`=idx for one cycle.
  - `err`=1 if code=30.
- Holding a pair longer than STABLE produces no further commits. A pair that changes and then returns commits again, and `upd` pulses even if the stored code is unchanged.
- `dig_en` all-zero (blanking interval) or multi-hot never qualifies. The counter clears; stored codes are untouched.
- `RST` asserted mid-qualification discards the pending pair. No commit is issued that cycle or after release until STABLE fresh samples.

## Timing
- Reset values:
  - `codes` all 31 (blank).
  - `valid`=0, `upd`=0, `upd_idx`=0, `err`=0.
  - Sample registers and counter = 0.
- Latency: if a qualifying pair is first sampled at edge 0 and held through edge STABLE-1, then `upd`/`codes`/`valid`/`err` update at edge STABLE. `upd` is high for the cycle following that edge. End-to-end this is STABLE+1 edges from input-apply-before-edge-0.
- A change at edge STABLE-1 or earlier aborts the commit.
- `upd`, `err`, and `upd_idx` are registered outputs. `upd_idx` holds its last value when `upd`=0.
- Commits are at least STABLE cycles apart; no back-to-back pulses.
- `RST` has priority over a coincident commit.

## Structure
- Package `seg7_pkg`:
  - Code constants `CODE_MINUS`=16, `CODE_BAD`=30, `CODE_BLANK`=31.
  - Segment-pattern constants for codes 0–16, shared with the encoder side.
- Sub-module `seg7_pattern_dec`: purely combinational 7-bit pattern to 5-bit code plus recognised flag; the only place the table lives.
- Top level holds the sample registers, stability counter (width $clog2(STABLE)+1), one-hot check, index encoder and register bank.

## Test plan
- Reset, then idle: `codes` all 31, `valid`=0, no `upd` for 100 cycles with `dig_en`=0.
- STABLE=4, `seg_in`=8'hB6, `dig_en`=8'h04 held 10 cycles → single `upd` at edge 4 after first sample; `upd_idx`=2, `codes[2]`=5, `valid`=8'h04, `err`=0.
- Same pair held only 3 cycles, then `dig_en`=0 → no `upd`; `codes` unchanged.
- `seg_in`=8'h02 on digit 0, then 8'h00 on digit 1, then 8'hFF on digit 7:
  - digit 0: `codes[0]`=16.
  - digit 1: `codes[1]`=31 with `err`=0.
  - digit 7: `codes[7]`=8 (dp ignored).
- `seg_in`=8'h92 (unrecognised) on digit 3 → `codes[3]`=30, `err` pulses with `upd`; `dig_en`=8'h06 (multi-hot) held 20 cycles → no commit.
- Scan all 8 digits round-robin for 6 cycles each with values 0..7, then assert `RST` mid-hold of digit 0 → all positions decoded correctly before reset; after reset all 31, `valid`=0, and the aborted digit does not commit.
